// File: rtl/downlink_rx.sv
// Receive side of the AGC digital downlink. Resynchronises the DKSTRT/DKBSNC/DKEND
// strobes and DKDATA, samples one bit per bit-sync pulse, assembles 40-bit frames and
// hands them to the consumer through a single-entry holding register (valid/ready).
module downlink_rx #(
  parameter int unsigned SAMPLE_DLY = 3,
  parameter int unsigned NBITS      = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dkstrt,
  input  logic        dkbsnc,
  input  logic        dkend,
  input  logic        dkdata,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [15:0] word_a,
  output logic [15:0] word_b,
  output logic [7:0]  trailer,
  output logic        frame_err,
  output logic        overrun,
  input  logic        overrun_clr,
  output logic [15:0] frame_cnt
);

  localparam logic [3:0] DlyC   = 4'(SAMPLE_DLY);
  localparam logic [5:0] NbitsC = 6'(NBITS);

  typedef enum logic [1:0] {StIdle, StActive, StDeliver} state_e;

  // Synchroniser bit order: {dkdata, dkend, dkbsnc, dkstrt}
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [3:0]  sync3_q, sync3_d;
  logic [3:0]  tmr_q, tmr_d;
  logic        busy_q, busy_d;
  logic [39:0] shift_q, shift_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  state_e      state_q, state_d;
  logic [39:0] hold_q, hold_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        overrun_q, overrun_d;
  logic [15:0] cnt_q, cnt_d;

  logic        strt_rise, bsnc_rise, end_rise, data_s;
  logic        sample_now, overrun_set;
  logic [39:0] shift_eff;
  logic [5:0]  cnt_eff;

  // Next-state logic: synchronisers, sample timer, frame FSM and holding register
  always_comb begin
    sync1_d     = {dkdata, dkend, dkbsnc, dkstrt};
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    tmr_d       = tmr_q;
    busy_d      = busy_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    state_d     = state_q;
    hold_d      = hold_q;
    valid_d     = valid_q & ~frame_ready;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    overrun_set = 1'b0;
    sample_now  = 1'b0;

    strt_rise = sync2_q[0] & ~sync3_q[0];
    bsnc_rise = sync2_q[1] & ~sync3_q[1];
    end_rise  = sync2_q[2] & ~sync3_q[2];
    data_s    = sync2_q[3];

    // A fresh bit-sync rise always restarts the timer; a pending sample is dropped
    if (bsnc_rise) begin
      if (DlyC == 4'd0) begin
        sample_now = 1'b1;
        busy_d     = 1'b0;
      end else begin
        tmr_d  = DlyC;
        busy_d = 1'b1;
      end
    end else if (busy_q) begin
      if (tmr_q == 4'd1) begin
        sample_now = 1'b1;
        busy_d     = 1'b0;
      end else begin
        tmr_d = tmr_q - 4'd1;
      end
    end

    // Same-cycle sample is folded in before the DKEND bit-count check
    shift_eff = sample_now ? {shift_q[38:0], data_s} : shift_q;
    cnt_eff   = sample_now ? bitcnt_q + 6'd1 : bitcnt_q;

    unique case (state_q)
      StIdle: begin
        if (strt_rise) begin
          state_d  = StActive;
          shift_d  = '0;
          bitcnt_d = '0;
        end
      end
      StActive: begin
        shift_d  = shift_eff;
        bitcnt_d = cnt_eff;
        if (strt_rise) begin
          err_d    = 1'b1;
          shift_d  = '0;
          bitcnt_d = '0;
        end else if (sample_now && bitcnt_q == NbitsC) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (end_rise) begin
          if (cnt_eff == NbitsC) begin
            state_d = StDeliver;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StDeliver: begin
        state_d = StIdle;
        if (!valid_q || frame_ready) begin
          hold_d  = shift_q;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          overrun_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    overrun_d = (overrun_q & ~overrun_clr) | overrun_set;
  end

  // All state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      tmr_q     <= '0;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      state_q   <= StIdle;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      tmr_q     <= tmr_d;
      busy_q    <= busy_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  assign frame_valid = valid_q;
  assign word_a      = hold_q[39:24];
  assign word_b      = hold_q[23:8];
  assign trailer     = hold_q[7:0];
  assign frame_err   = err_q;
  assign overrun     = overrun_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_downlink_rx.sv
// Bench for downlink_rx: table of directed frames, hand sequences for latency, overrun,
// back-to-back and mid-frame reset, then random frames checked against a frame-level model.
module tb_downlink_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dkstrt = 1'b0, dkbsnc = 1'b0, dkend = 1'b0, dkdata = 1'b0;
  logic        frame_valid, frame_err, overrun;
  logic        frame_ready;
  logic        ready_man = 1'b0, rnd_ready = 1'b0, rand_mode = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [15:0] word_a, word_b, frame_cnt;
  logic [7:0]  trailer;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;
  int valid_cyc = 0;
  logic [39:0] got_q[$];
  logic [39:0] exp_q[$];

  assign frame_ready = rand_mode ? rnd_ready : ready_man;

  downlink_rx #(.SAMPLE_DLY(3), .NBITS(40)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dkstrt      (dkstrt),
    .dkbsnc      (dkbsnc),
    .dkend       (dkend),
    .dkdata      (dkdata),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .word_a      (word_a),
    .word_b      (word_b),
    .trailer     (trailer),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    rnd_ready = ($urandom_range(0, 3) == 0);
  end

  // Observe outputs on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_seen++;
      if (frame_valid) valid_cyc++;
      if (frame_valid && frame_ready) got_q.push_back({word_a, word_b, trailer});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dkstrt = 1'b0; dkbsnc = 1'b0; dkend = 1'b0; dkdata = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    got_q.delete();
  endtask

  task automatic strobe_start();
    @(negedge clk); dkstrt = 1'b1; cyc(3); dkstrt = 1'b0; cyc(4);
  endtask

  task automatic strobe_end();
    @(negedge clk); dkend = 1'b1; cyc(3); dkend = 1'b0; cyc(4);
  endtask

  task automatic send_bits(input logic [39:0] bits, input int n, input int period);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dkdata = (i < 40) ? bits[39 - i] : 1'b0;
      @(negedge clk); dkbsnc = 1'b1;
      cyc(3); dkbsnc = 1'b0;
      cyc(period - 5);
    end
  endtask

  task automatic send_frame(input logic [39:0] bits, input int n, input int period);
    strobe_start();
    send_bits(bits, n, period);
    strobe_end();
  endtask

  typedef struct {
    logic [39:0] data;
    int          nbits;
    int          pre;
    int          exp_good;
    int          exp_err;
  } vec_t;

  vec_t tbl[5];
  int   exp_cnt;
  int   e0, v0;
  logic [39:0] f, exp_f, got_f;

  initial begin
    tbl[0] = '{40'hA5A5_0F0F_3C, 40, 0,  1, 0};
    tbl[1] = '{40'hA5A5_0F0F_3C, 39, 0,  0, 1};
    tbl[2] = '{40'h1234_5678_9A, 40, 12, 1, 1};
    tbl[3] = '{40'h0000_0000_01, 40, 0,  1, 0};
    tbl[4] = '{40'hFFFF_FFFF_FF, 41, 0,  0, 1};

    // Reset state
    cyc(2);
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_data", 64'({word_a, word_b, trailer}), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    chk("rst_cnt", 64'(frame_cnt), 64'd0);
    do_reset();

    // Table-driven frames, consumer always ready
    ready_man = 1'b1;
    exp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      e0 = err_seen;
      got_q.delete();
      if (tbl[k].pre > 0) begin
        strobe_start();
        send_bits(40'hDEAD_BEEF_77, tbl[k].pre, 20);
      end
      send_frame(tbl[k].data, tbl[k].nbits, 20);
      cyc(10);
      exp_cnt += tbl[k].exp_good;
      chk($sformatf("tbl%0d_err", k), 64'(err_seen - e0), 64'(tbl[k].exp_err));
      chk($sformatf("tbl%0d_nacc", k), 64'(got_q.size()), 64'(tbl[k].exp_good));
      if (tbl[k].exp_good != 0 && got_q.size() > 0)
        chk($sformatf("tbl%0d_data", k), 64'(got_q[0]), 64'(tbl[k].data));
      chk($sformatf("tbl%0d_cnt", k), 64'(frame_cnt), 64'(exp_cnt));
      chk($sformatf("tbl%0d_valid", k), 64'(frame_valid), 64'd0);
    end

    // Latency and overrun: consumer stalled
    do_reset();
    ready_man = 1'b0;
    strobe_start();
    send_bits(40'hC3C3_2121_E7, 40, 16);
    @(negedge clk); dkend = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat_valid_c%0d", k), 64'(frame_valid), 64'(k == 4));
    end
    dkend = 1'b0;
    cyc(5);
    send_frame(40'h1111_2222_33, 40, 16);
    cyc(5);
    chk("ovr_set", 64'(overrun), 64'd1);
    chk("ovr_valid", 64'(frame_valid), 64'd1);
    chk("ovr_hold", 64'({word_a, word_b, trailer}), 64'h00C3C3_2121_E7);
    chk("ovr_cnt", 64'(frame_cnt), 64'd1);
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    chk("ovr_clr", 64'(overrun), 64'd0);
    chk("ovr_clr_hold", 64'(frame_valid), 64'd1);
    @(negedge clk); ready_man = 1'b1;
    @(negedge clk); ready_man = 1'b0;
    chk("ovr_drain", 64'(frame_valid), 64'd0);

    // Back-to-back frames, consumer always ready
    do_reset();
    ready_man = 1'b1;
    v0 = valid_cyc;
    for (int k = 0; k < 3; k++) send_frame(40'h0101_0202_03 + 40'(k), 40, 10);
    cyc(10);
    chk("b2b_validcyc", 64'(valid_cyc - v0), 64'd3);
    chk("b2b_nacc", 64'(got_q.size()), 64'd3);
    chk("b2b_cnt", 64'(frame_cnt), 64'd3);
    chk("b2b_ovr", 64'(overrun), 64'd0);

    // Reset in mid-frame at bit 20
    ready_man = 1'b0;
    send_frame(40'h7777_8888_99, 40, 10);
    cyc(5);
    strobe_start();
    send_bits(40'hAAAA_AAAA_AA, 20, 12);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(frame_valid), 64'd0);
    chk("mid_rst_data", 64'({word_a, word_b, trailer}), 64'd0);
    chk("mid_rst_cnt", 64'(frame_cnt), 64'd0);
    chk("mid_rst_err", 64'({frame_err, overrun}), 64'd0);
    cyc(2); rst_n = 1'b1; cyc(2);
    got_q.delete();
    ready_man = 1'b1;
    send_frame(40'hFFFF_0000_81, 40, 12);
    cyc(10);
    chk("mid_rst_nacc", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("mid_rst_frame", 64'(got_q[0]), 64'hFFFF_0000_81);
    chk("mid_rst_cnt2", 64'(frame_cnt), 64'd1);

    // Random frames vs frame-level model: a frame is good iff exactly 40 bit pulses follow its
    // final start; every short/long frame and every restart costs one error pulse
    do_reset();
    rand_mode = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    e0 = err_seen;
    begin
      int exp_err = 0;
      for (int k = 0; k < 14; k++) begin
        int r, n, per;
        f   = {$urandom(), 8'($urandom())};
        r   = int'($urandom_range(0, 5));
        n   = (r == 0) ? 39 : (r == 1) ? 41 : 40;
        per = int'($urandom_range(8, 20));
        if ($urandom_range(0, 3) == 0) begin
          strobe_start();
          send_bits(~f, int'($urandom_range(1, 39)), per);
          exp_err++;
        end
        send_frame(f, n, per);
        if (n == 40) begin
          exp_q.push_back(f);
          exp_cnt++;
        end else begin
          exp_err++;
        end
      end
      cyc(60);
      chk("rnd_err", 64'(err_seen - e0), 64'(exp_err));
    end
    chk("rnd_nacc", 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      got_f = got_q.pop_front();
      exp_f = exp_q.pop_front();
      chk("rnd_frame", 64'(got_f), 64'(exp_f));
    end
    chk("rnd_cnt", 64'(frame_cnt), 64'(exp_cnt));
    chk("rnd_ovr", 64'(overrun), 64'd0);
    chk("rnd_valid", 64'(frame_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
